adder_operand_loader: RTL
=========================

// Module: adder_operand_loader
// PURPOSE
//  Upstream stage of the 3-bit ripple adder user design. Captures operands A and B
//  serially from slow, asynchronous pin inputs (bit + strobe + frame start), then
//  presents them in parallel with a valid/ready handshake to the adder.
//  Replaces the static 6-pin operand wiring, freeing pins for sum/carry output.
// PARAMETERS
//  WIDTH        3  operand width in bits (A and B each)
//  SYNC_STAGES  2  flops in each input synchronizer (>=2)
// PORTS
//  clk          in   1      design clock (io_in[0] at the top level)
//  rst_n        in   1      asynchronous active-low reset
//  ser_in       in   1      serial operand bit, async pin, MSB first
//  ser_strobe   in   1      async pin; rising edge = sample ser_in
//  frame_start  in   1      async pin; rising edge = begin/restart a frame
//  op_a         out  WIDTH  captured operand A
//  op_b         out  WIDTH  captured operand B
//  op_valid     out  1      op_a/op_b valid for consumer
//  op_ready     in   1      consumer accepts (adder may tie high)
//  busy         out  1      state != IDLE
//  err          out  1      sticky parity error (0 unless PARITY_CHECK_EN)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, bit_cnt 0, synchronizer flops 0.
//  - ser_in/ser_strobe/frame_start each pass SYNC_STAGES flops; edge detect on the
//    synchronized value. Pin edge -> sample event after SYNC_STAGES+1 clk.
//  - States: IDLE, LOAD_A, LOAD_B, HOLD (+PAR_A, PAR_B with macro).
//  - IDLE: frame_start edge -> LOAD_A, bit_cnt=0. Strobes ignored.
//  - LOAD_A: each sample event shifts synced ser_in into A shreg (MSB first),
//    bit_cnt++; at WIDTH bits -> LOAD_B, bit_cnt=0. LOAD_B identical -> HOLD.
//  - HOLD: op_valid=1 registered, op_a/op_b stable. op_valid&op_ready -> IDLE,
//    op_valid=0 next clk. op_a/op_b retain values after handshake (not cleared).
//  - op_ready tied high: op_valid is exactly one clk pulse.
//  - frame_start edge in LOAD_*/PAR_*: restart at LOAD_A, partial bits discarded;
//    wins over a same-cycle sample event (sample dropped). In HOLD: ignored.
//  - Strobe held high: one sample only (edge detect). Strobes in HOLD ignored.
//  - bit_cnt width $clog2(WIDTH+1); never exceeds WIDTH.
//  - Shift registers are internal; op_a/op_b update only on entry to HOLD.
// CONFIGURATION
//  PARITY_CHECK_EN defined: after WIDTH bits of each operand one extra sample
//   (PAR_A / PAR_B) carries an even-parity bit (^operand ^ par must be 0).
//   Mismatch -> err=1 (sticky), return to IDLE, no op_valid. err cleared on next
//   frame_start edge. Frame length 2*WIDTH+2 samples.
//  Undefined: no parity states, frame = 2*WIDTH samples, err tied 0.
// STRUCTURE
//  - Package adder_loader_pkg: state enum (IDLE, LOAD_A, LOAD_B, PAR_A, PAR_B,
//    HOLD), default WIDTH constant.
//  - Sub-module edge_sync: SYNC_STAGES synchronizer + rising-edge pulse, one
//    instance per async input (ser_in uses level output only).
//  - Top: FSM, bit counter, two shift registers, output registers.
// TESTING
//  1. Reset asserted mid-LOAD_B -> op_valid=0, op_a=op_b=0, busy=0, err=0 at once.
//  2. Frame A=101,B=011, op_ready=1 -> op_valid one clk, op_a=5, op_b=3, busy->0.
//  3. Same frame, op_ready=0 for 10 clk + extra strobes -> op_valid held, op_a=5,
//     op_b=3 unchanged; op_ready=1 -> IDLE next clk.
//  4. 2 bits of A, then frame_start, then A=110,B=001 -> op_a=6, op_b=1.
//  5. Strobe held high 20 clk in LOAD_A -> bit_cnt advances by exactly 1.
//  6. PARITY_CHECK_EN: A=101 par=1 -> err=1, no op_valid; next frame clears err,
//     A=101 par=0,B=011 par=0 -> op_a=5, op_b=3. Macro off: err stays 0.

Source files
------------

// File: rtl/adder_loader_pkg.sv
// Shared types for the serial operand loader: FSM state encoding and default operand width.
package adder_loader_pkg;

   localparam int DEF_WIDTH = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      PAR_A  = 3'd3,
      PAR_B  = 3'd4,
      HOLD   = 3'd5
   } loader_state_t;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for a slow asynchronous pin, with a one-clock rising-edge pulse
// derived from the synchronized level.
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic level_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/adder_operand_loader.sv
// Serial-to-parallel operand loader for the 3-bit ripple adder: captures A then B MSB first,
// then holds them behind a valid/ready handshake. Optional parity bits: define PARITY_CHECK_EN.
module adder_operand_loader
   import adder_loader_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ser_in,
   input  logic             ser_strobe,
   input  logic             frame_start,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             op_valid,
   input  logic             op_ready,
   output logic             busy,
   output logic             err
);

   localparam int CW = $clog2(WIDTH + 1);

   loader_state_t    state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
   logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   logic ser_lvl, ser_rise_unused, smp, fs_rise, last_bit;

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ser (
      .clk(clk), .rst_n(rst_n), .async_i(ser_in), .level_o(ser_lvl), .rise_o(ser_rise_unused)
   );

   logic strobe_lvl_unused;
   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_strobe (
      .clk(clk), .rst_n(rst_n), .async_i(ser_strobe), .level_o(strobe_lvl_unused), .rise_o(smp)
   );

   logic fs_lvl_unused;
   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fs (
      .clk(clk), .rst_n(rst_n), .async_i(frame_start), .level_o(fs_lvl_unused), .rise_o(fs_rise)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_a_q  <= '0;
         sh_b_q  <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_a_q  <= sh_a_d;
         sh_b_q  <= sh_b_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_a_d   = sh_a_q;
      sh_b_d   = sh_b_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      valid_d  = valid_q;
      err_d    = err_q;
      last_bit = (cnt_q == CW'(WIDTH - 1));

      // A frame_start edge outranks a same-cycle sample everywhere except HOLD.
      if (fs_rise && state_q != HOLD) begin
         state_d = LOAD_A;
         cnt_d   = '0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;
            LOAD_A: if (smp) begin
               sh_a_d = {sh_a_q[WIDTH-2:0], ser_lvl};
               cnt_d  = cnt_q + CW'(1);
               if (last_bit) begin
                  cnt_d = '0;
`ifdef PARITY_CHECK_EN
                  state_d = PAR_A;
`else
                  state_d = LOAD_B;
`endif
               end
            end
            LOAD_B: if (smp) begin
               sh_b_d = {sh_b_q[WIDTH-2:0], ser_lvl};
               cnt_d  = cnt_q + CW'(1);
               if (last_bit) begin
                  cnt_d = '0;
`ifdef PARITY_CHECK_EN
                  state_d = PAR_B;
`else
                  state_d = HOLD;
                  op_a_d  = sh_a_q;
                  op_b_d  = sh_b_d;
                  valid_d = 1'b1;
`endif
               end
            end
`ifdef PARITY_CHECK_EN
            PAR_A: if (smp) begin
               if (^sh_a_q ^ ser_lvl) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = LOAD_B;
               end
            end
            PAR_B: if (smp) begin
               if (^sh_b_q ^ ser_lvl) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = HOLD;
                  op_a_d  = sh_a_q;
                  op_b_d  = sh_b_q;
                  valid_d = 1'b1;
               end
            end
`endif
            HOLD: if (valid_q && op_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign op_a     = op_a_q;
   assign op_b     = op_b_q;
   assign op_valid = valid_q;
   assign busy     = (state_q != IDLE);
   assign err      = err_q;

endmodule
